// File: rtl/if_fetch_pkg.sv
// Shared bus widths, constants and address helpers for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_t ZERO_WORD      = 32'h0000_0000;
    localparam logic  RST_ENABLE     = 1'b1;
    localparam logic  RST_DISABLE    = 1'b0;
    localparam logic  CHIP_ENABLE    = 1'b1;
    localparam logic  CHIP_DISABLE   = 1'b0;

    // Instructions are always word aligned: the two low address bits are dropped.
    function automatic inst_addr_t word_base(input inst_addr_t addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped, one-word-per-line instruction cache used by if_fetch when IF_ICACHE_EN is defined.
module if_icache
    import if_fetch_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] i_rd_waddr,
    output logic        o_hit,
    output inst_t       o_rd_word,
    input  logic        i_wr_en,
    input  logic [29:0] i_wr_waddr,
    input  inst_t       i_wr_word
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    inst_t            r_data [LINES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0] w_wr_tag;

    assign w_rd_idx = i_rd_waddr[IDX_W-1:0];
    assign w_rd_tag = i_rd_waddr[29:IDX_W];
    assign w_wr_idx = i_wr_waddr[IDX_W-1:0];
    assign w_wr_tag = i_wr_waddr[29:IDX_W];

    assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_word = r_data[w_rd_idx];

    // Only reset invalidates lines; code is assumed never to be rewritten at run time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_valid <= {LINES{1'b0}};
        end else if (i_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= i_wr_word;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// RV32I instruction fetch: assembles each word from four byte reads of the unified RAM.
// Optional direct-mapped instruction cache enabled by defining IF_ICACHE_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    input  logic [7:0]  mem_din_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD1   = 3'd1;
    localparam logic [2:0] S_RD2   = 3'd2;
    localparam logic [2:0] S_RD3   = 3'd3;
    localparam logic [2:0] S_RD4   = 3'd4;
    localparam logic [2:0] S_VALID = 3'd5;

    logic [2:0]  r_state;
    inst_addr_t  r_pc;
    inst_t       r_inst;
    logic        r_valid;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    logic [7:0]  r_b2;
    inst_addr_t  r_last_addr;

    logic        w_req_state;
    logic [1:0]  w_byte_idx;
    inst_addr_t  w_req_addr;
    logic        w_cache_hit;
    inst_t       w_cache_word;
    logic        w_lookup_hit;
    inst_t       w_ram_word;

    // A non-power-of-two line count would make the cache index ambiguous.
    if ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_icache_lines_not_pow2
    end

    assign w_ram_word   = {mem_din_i, r_b2, r_b1, r_b0};
    assign w_lookup_hit = (r_state == S_IDLE) && w_cache_hit;

`ifdef IF_ICACHE_EN
    logic w_fill;

    assign w_fill = (r_state == S_RD4) && !branch_flag_i;

    if_icache #(
        .LINES      (ICACHE_LINES)
    ) u_icache (
        .clk        (clk),
        .rst        (rst),
        .i_rd_waddr (r_pc[31:2]),
        .o_hit      (w_cache_hit),
        .o_rd_word  (w_cache_word),
        .i_wr_en    (w_fill),
        .i_wr_waddr (r_pc[31:2]),
        .i_wr_word  (w_ram_word)
    );
`else
    assign w_cache_hit  = 1'b0;
    assign w_cache_word = ZERO_WORD;
`endif

    // Request decode: byte index per read state; a redirect or reset suppresses the request.
    always_comb begin
        w_req_state = 1'b0;
        w_byte_idx  = 2'd0;
        case (r_state)
            S_IDLE: begin
                w_req_state = !w_cache_hit;
                w_byte_idx  = 2'd0;
            end
            S_RD1: begin
                w_req_state = 1'b1;
                w_byte_idx  = 2'd1;
            end
            S_RD2: begin
                w_req_state = 1'b1;
                w_byte_idx  = 2'd2;
            end
            S_RD3: begin
                w_req_state = 1'b1;
                w_byte_idx  = 2'd3;
            end
            default: begin
                w_req_state = 1'b0;
                w_byte_idx  = 2'd0;
            end
        endcase
        w_req_addr = word_base(r_pc) + {30'd0, w_byte_idx};
        mem_req_o  = w_req_state && !branch_flag_i && (rst != RST_ENABLE);
        if (mem_req_o) begin
            mem_addr_o = w_req_addr;
        end else begin
            mem_addr_o = r_last_addr;
        end
    end

    // The RAM address bus keeps its last driven value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_last_addr <= 32'h0000_0000;
        end else if (mem_req_o) begin
            r_last_addr <= w_req_addr;
        end else begin
            r_last_addr <= r_last_addr;
        end
    end

    // Fetch sequencer; a redirect from decode overrides every state, discarding partial bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state <= S_IDLE;
            r_pc    <= word_base(RESET_PC);
            r_inst  <= ZERO_WORD;
            r_valid <= 1'b0;
            r_b0    <= 8'h00;
            r_b1    <= 8'h00;
            r_b2    <= 8'h00;
        end else if (branch_flag_i) begin
            r_state <= S_IDLE;
            r_pc    <= word_base(branch_addr_i);
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_lookup_hit) begin
                        r_inst  <= w_cache_word;
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                    end else begin
                        r_state <= S_RD1;
                    end
                end
                S_RD1: begin
                    r_b0    <= mem_din_i;
                    r_state <= S_RD2;
                end
                S_RD2: begin
                    r_b1    <= mem_din_i;
                    r_state <= S_RD3;
                end
                S_RD3: begin
                    r_b2    <= mem_din_i;
                    r_state <= S_RD4;
                end
                S_RD4: begin
                    r_inst  <= w_ram_word;
                    r_valid <= 1'b1;
                    r_state <= S_VALID;
                end
                S_VALID: begin
                    if (!stall_i) begin
                        r_pc    <= r_pc + 32'd4;
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_VALID;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;

endmodule
